wr_ptr_ctrl: RTL and testbench

Parametrised write-side pointer controller for the dual-clock FIFO, replacing the fixed full-only write pointer block. It lives entirely in the write clock domain. It synchronises the read domain's Gray pointer internally, generates the binary memory write address and the Gray write pointer for the read domain, and produces registered full, almost-full, fill-level and sticky overflow status.

---
 rtl/fifo_pkg.sv | 52 +++++
 rtl/sync_nff.sv | 42 ++++
 rtl/wr_ptr_ctrl.sv | 116 +++++++++++
 tb/tb_wr_ptr_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the dual-clock FIFO pointer controllers (write side,
// read side) and the async FIFO top: depth derivation and Gray/binary
// conversion helpers.
//
// The conversion helpers work on a fixed maximum-width word. The caller passes
// the real pointer width, and bits at or above that width are ignored. This
// gives one function body for every pointer width without needing
// parametrised classes.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // FIFO depth in words for a given address width.
   function automatic int unsigned fifo_depth(input int unsigned addrsize);
      return 32'd1 << addrsize;
   endfunction

   // Binary to Gray conversion over the low 'width' bits.
   function automatic gray_word_t bin2gray(input gray_word_t bin, input int width);
      gray_word_t gray;
      gray = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         if (i < width) begin
            if (i + 1 < width) gray[i] = bin[i] ^ bin[i+1];
            else               gray[i] = bin[i];
         end
      end
      return gray;
   endfunction

   // Gray to binary conversion over the low 'width' bits.
   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic gray_word_t gray2bin(input gray_word_t gray, input int width);
      gray_word_t bin;
      logic       acc;
      bin = '0;
      acc = 1'b0;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i < width) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
         end
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_nff.sv
// -----------------------------------------------------------------------------
// sync_nff
// Multi-flop synchroniser for a bus that changes by at most one bit per source
// clock, such as a Gray pointer. The output lags the input by STAGES edges of
// clk.
//
// Ports:
//   clk    in   destination-domain clock
//   rst_n  in   asynchronous active-low reset; clears every stage
//   d_i    in   WIDTH-bit input from the foreign clock domain
//   q_o    out  WIDTH-bit synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_nff #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: these are real flops rather than a RAM, so resetting every
         // stage costs nothing and makes the synchronised value well defined
         // right after reset.
         for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample its
         // predecessor's old value, so the chain shifts one stage per edge
         // regardless of statement order.
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ptr_ctrl
// Write-side pointer controller of the dual-clock FIFO. It lives entirely in
// the write clock domain. It synchronises the read Gray pointer, keeps the
// binary and Gray write pointers, and produces registered full, almost-full,
// fill-level and sticky overflow status.
//
// The status is pessimistic. Reads become visible only after synchronisation,
// so wcount may overstate the fill level but never understates it.
//
// Ports:
//   wr_clk        in   write-domain clock
//   wr_rst_n      in   asynchronous active-low reset
//   wr_en         in   write request
//   ovf_clr       in   clears the sticky overflow flag
//   rptr_gray     in   read-domain Gray pointer (unsynchronised)
//   wr_accept     out  memory write enable, wr_en & ~wfull (combinational)
//   wr_addr       out  binary memory write address
//   wptr          out  registered Gray write pointer for the read domain
//   wfull         out  registered full flag
//   walmost_full  out  registered almost-full flag (fill >= AFULL_LEVEL)
//   wcount        out  registered fill level, 0..DEPTH
//   wovf          out  sticky overflow flag (write attempted while full)
// -----------------------------------------------------------------------------
module wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDRSIZE    = 4,
   parameter int unsigned AFULL_LEVEL = fifo_depth(ADDRSIZE) - 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                wr_clk,
   input  logic                wr_rst_n,
   input  logic                wr_en,
   input  logic                ovf_clr,
   input  logic [ADDRSIZE:0]   rptr_gray,
   output logic                wr_accept,
   output logic [ADDRSIZE-1:0] wr_addr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wcount,
   output logic                wovf
);

   localparam int unsigned       PTR_W     = ADDRSIZE + 1;
   // AFULL_LEVEL can be as large as DEPTH, which fits in the pointer width.
   localparam logic [ADDRSIZE:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

   logic [ADDRSIZE:0] wq_rptr;
   logic [ADDRSIZE:0] rbin_s;
   logic [ADDRSIZE:0] wbin_q,   wbin_d;
   logic [ADDRSIZE:0] wptr_q,   wgray_d;
   logic [ADDRSIZE:0] wcount_q, count_d;
   logic              wfull_q,  full_d;
   logic              wafull_q, afull_d;
   logic              wovf_q,   wovf_d;

   // Read pointer into the write domain.
   sync_nff #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk   (wr_clk),
      .rst_n (wr_rst_n),
      .d_i   (rptr_gray),
      .q_o   (wq_rptr)
   );

   assign rbin_s = PTR_W'(gray2bin(GRAY_MAX_W'(wq_rptr), int'(PTR_W)));

   // Gated by the registered full flag only, so there is no combinational path
   // from the read pointer to the memory write enable.
   assign wr_accept = wr_en & ~wfull_q;

   assign wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wr_accept};
   assign wgray_d = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d), int'(PTR_W)));

   // The MSB is a lap bit, so the modulo difference is the true fill level
   // even across the pointer wrap.
   assign count_d = wbin_d - rbin_s;

   // Full means "same address, one lap ahead". In Gray code this is the read
   // pointer with its two top bits inverted.
   assign full_d  = (wgray_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
   assign afull_d = (count_d >= AFULL_THR);

   // A set in the same cycle as a clear wins.
   assign wovf_d  = (wr_en & wfull_q) | (wovf_q & ~ovf_clr);

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wcount_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wgray_d;
         wcount_q <= count_d;
         wfull_q  <= full_d;
         wafull_q <= afull_d;
         wovf_q   <= wovf_d;
      end
   end

   assign wr_addr      = wbin_q[ADDRSIZE-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = wafull_q;
   assign wcount       = wcount_q;
   assign wovf         = wovf_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ptr_ctrl
// Scoreboard bench for wr_ptr_ctrl with default parameters.
//
// The stimulus process keeps a reference model of the FIFO. The model counts
// total writes and the read position as plain integers, and delays the read
// position by the synchroniser latency. For every cycle it drives, it pushes
// the expected outputs into a queue. A separate monitor pops one entry per
// clock and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_wr_ptr_ctrl;

   localparam int ADDRSIZE = 4;
   localparam int DEPTH    = 16;
   localparam int AFULL    = 14;
   localparam int SYNC     = 2;

   logic                wr_clk;
   logic                wr_rst_n;
   logic                wr_en;
   logic                ovf_clr;
   logic [ADDRSIZE:0]   rptr_gray;
   logic                wr_accept;
   logic [ADDRSIZE-1:0] wr_addr;
   logic [ADDRSIZE:0]   wptr;
   logic                wfull;
   logic                walmost_full;
   logic [ADDRSIZE:0]   wcount;
   logic                wovf;

   wr_ptr_ctrl #(
      .ADDRSIZE    (ADDRSIZE),
      .AFULL_LEVEL (AFULL),
      .SYNC_STAGES (SYNC)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst_n     (wr_rst_n),
      .wr_en        (wr_en),
      .ovf_clr      (ovf_clr),
      .rptr_gray    (rptr_gray),
      .wr_accept    (wr_accept),
      .wr_addr      (wr_addr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wcount       (wcount),
      .wovf         (wovf)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      bit acc;
      int addr;
      int wptr;
      bit full;
      bit afull;
      int count;
      bit ovf;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int w_tot;        // accepted writes since reset
   int rd_tot;       // read position currently driven
   int r_hist[$];    // read positions of the last SYNC cycles
   bit m_full;
   bit m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   function automatic int gray5(input int b);
      int v;
      v = b % (2 * DEPTH);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      w_tot  = 0;
      rd_tot = 0;
      r_hist = {};
      for (int i = 0; i < SYNC; i++) r_hist.push_back(0);
      m_full = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Drive one cycle and push the outputs expected after the following edge.
   task automatic step(input bit en, input bit clr, input int rd_target);
      exp_t e;
      int   rs;
      int   cnt;
      @(negedge wr_clk);
      #1;
      wr_en     = en;
      ovf_clr   = clr;
      rd_tot    = rd_target;
      rptr_gray = 5'(gray5(rd_tot));
      e.acc = en && !m_full;
      if (e.acc) w_tot++;
      r_hist.push_back(rd_tot);
      rs  = r_hist.pop_front();   // read position from SYNC cycles ago
      cnt = w_tot - rs;
      e.count = cnt;
      e.full  = (cnt == DEPTH);
      e.afull = (cnt >= AFULL);
      e.ovf   = (en && m_full) || (m_ovf && !clr);
      e.addr  = w_tot % DEPTH;
      e.wptr  = gray5(w_tot);
      m_full  = e.full;
      m_ovf   = e.ovf;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_wptr"},    32'(wptr), 0);
      check({tag, "_wfull"},   32'(wfull), 0);
      check({tag, "_wafull"},  32'(walmost_full), 0);
      check({tag, "_wcount"},  32'(wcount), 0);
      check({tag, "_wovf"},    32'(wovf), 0);
   endtask

   // Monitor: accept is sampled mid-cycle, registered outputs after the edge.
   initial begin : monitor
      exp_t e;
      logic acc_seen;
      forever begin
         @(negedge wr_clk);
         #3;
         acc_seen = wr_accept;
         @(posedge wr_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_accept",    32'(acc_seen), 32'(e.acc));
            check("wr_addr",      32'(wr_addr), e.addr);
            check("wptr",         32'(wptr), e.wptr);
            check("wfull",        32'(wfull), 32'(e.full));
            check("walmost_full", 32'(walmost_full), 32'(e.afull));
            check("wcount",       32'(wcount), e.count);
            check("wovf",         32'(wovf), 32'(e.ovf));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int rd_pct;
      wr_rst_n  = 1'b1;
      wr_en     = 1'b0;
      ovf_clr   = 1'b0;
      rptr_gray = '0;
      model_reset();
      #1;
      wr_rst_n = 1'b0;
      #2;
      check_all_zero("reset");
      check("reset_wr_accept", 32'(wr_accept), 0);
      @(negedge wr_clk);
      #1;
      wr_rst_n = 1'b1;

      // Fill from empty with the read pointer held at zero.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0);
      @(posedge wr_clk);
      #2;
      check("fill_wptr",  32'(wptr), 32'b11000);
      check("fill_wfull", 32'(wfull), 1);

      // Overflow attempts, then clear with no write.
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      // Set again, then set and clear together: the set wins.
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 0);
      step(1'b0, 1'b1, 0);

      // Read release: four words read at once.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4);

      // Random traffic with varying read rates, wrapping the pointers many times.
      for (int phase = 0; phase < 3; phase++) begin
         rd_pct = (phase == 0) ? 70 : (phase == 1) ? 40 : 10;
         for (int i = 0; i < 200; i++) begin
            bit en, clr;
            int rd;
            en  = ($urandom_range(99) < 75);
            clr = ($urandom_range(99) < 8);
            rd  = rd_tot;
            if (($urandom_range(99) < rd_pct) && (rd_tot < w_tot)) rd = rd_tot + 1;
            step(en, clr, rd);
         end
      end

      // Asynchronous reset from an arbitrary state, then fill to nine words.
      @(negedge wr_clk);
      #1;
      wr_rst_n  = 1'b0;
      wr_en     = 1'b0;
      rptr_gray = '0;
      #1;
      check_all_zero("rst_a");
      model_reset();
      @(negedge wr_clk);
      #1;
      wr_rst_n = 1'b1;
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0);

      // Reset mid-burst between edges while writing.
      @(negedge wr_clk);
      #1;
      wr_rst_n = 1'b0;
      #1;
      check_all_zero("rst_b");
      check("rst_b_wr_accept", 32'(wr_accept), 1);
      model_reset();
      @(negedge wr_clk);
      #1;
      wr_en    = 1'b0;
      wr_rst_n = 1'b1;
      #1;
      check("post_reset_wr_addr", 32'(wr_addr), 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);

      repeat (3) @(posedge wr_clk);
      #2;
      check("scoreboard_drain", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
